// File: rtl/block_dispatcher.sv
// Kernel launch front-end: holds the thread-count DCR, splits a launch into
// fixed-size blocks and hands them to the compute cores until all complete.
module block_dispatcher #(
    parameter  int NUM_CORES         = 2,
    parameter  int THREADS_PER_BLOCK = 4,
    localparam int TW                = $clog2(THREADS_PER_BLOCK) + 1
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    start,
    output logic                    done,
    input  logic                    device_control_write_enable,
    input  logic [7:0]              device_control_data,
    output logic [7:0]              thread_count,
    input  logic [NUM_CORES-1:0]    core_done,
    output logic [NUM_CORES-1:0]    core_start,
    output logic [NUM_CORES-1:0]    core_reset,
    output logic [NUM_CORES*8-1:0]  core_block_id,
    output logic [NUM_CORES*TW-1:0] core_thread_count
);

    localparam int LOG_TPB = $clog2(THREADS_PER_BLOCK);
    localparam int IW      = (NUM_CORES > 1) ? $clog2(NUM_CORES) : 1;

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_DONE
    } state_t;

    state_t state, state_next;

    logic [7:0]           dcr;
    logic [7:0]           tc;
    logic [8:0]           total_blocks;
    logic [8:0]           blocks_dispatched;
    logic [8:0]           blocks_done;
    logic [NUM_CORES-1:0] start_q;
    logic [NUM_CORES-1:0] reset_q;
    logic [7:0]           block_id_q [NUM_CORES];
    logic [TW-1:0]        thread_cnt_q [NUM_CORES];

    logic [NUM_CORES-1:0] complete;
    logic [8:0]           done_count;
    logic                 dispatch_valid;
    logic [IW-1:0]        dispatch_idx;
    logic                 last_block;
    logic [8:0]           remaining;

    assign thread_count = dcr;
    assign core_start   = start_q;
    assign core_reset   = reset_q;

    for (genvar g = 0; g < NUM_CORES; g++) begin : g_flatten
        assign core_block_id[8*g +: 8]      = block_id_q[g];
        assign core_thread_count[TW*g +: TW] = thread_cnt_q[g];
    end

    assign last_block = (blocks_dispatched == total_blocks - 9'd1);
    assign remaining  = {1'b0, tc} - (blocks_dispatched << LOG_TPB);

    // NOTE: every signal driven here gets a default first, so no path leaves
    // a value unassigned and no latch is inferred.
    always_comb begin
        state_next     = state;
        complete       = '0;
        done_count     = '0;
        dispatch_valid = 1'b0;
        dispatch_idx   = '0;

        for (int i = 0; i < NUM_CORES; i++) begin
            complete[i] = start_q[i] & core_done[i];
            done_count  = done_count + 9'(complete[i]);
        end

        // Scan downward so the lowest-index idle core wins.
        for (int i = NUM_CORES - 1; i >= 0; i--) begin
            if (reset_q[i] && !start_q[i]) begin
                dispatch_valid = 1'b1;
                dispatch_idx   = IW'(i);
            end
        end
        dispatch_valid = dispatch_valid && (blocks_dispatched < total_blocks);

        case (state)
            S_IDLE:  if (start) state_next = S_RUN;
            S_RUN:   if (blocks_done == total_blocks) state_next = S_DONE;
            S_DONE:  state_next = S_DONE;
            default: state_next = S_IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments only, so every
    // rule below sees pre-edge values regardless of statement order.
    always_ff @(posedge clk) begin
        if (reset) state <= S_IDLE;
        else       state <= state_next;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            dcr               <= '0;
            tc                <= '0;
            total_blocks      <= '0;
            blocks_dispatched <= '0;
            blocks_done       <= '0;
            done              <= 1'b0;
            start_q           <= '0;
            reset_q           <= '1;
            for (int i = 0; i < NUM_CORES; i++) begin
                block_id_q[i]   <= '0;
                thread_cnt_q[i] <= TW'(THREADS_PER_BLOCK);
            end
        end else begin
            if (device_control_write_enable) dcr <= device_control_data;

            case (state)
                S_IDLE: begin
                    if (start) begin
                        tc                <= dcr;
                        total_blocks      <= ({1'b0, dcr} + 9'(THREADS_PER_BLOCK - 1)) >> LOG_TPB;
                        blocks_dispatched <= '0;
                        blocks_done       <= '0;
                    end
                end
                S_RUN: begin
                    blocks_done <= blocks_done + done_count;
                    for (int i = 0; i < NUM_CORES; i++) begin
                        if (complete[i]) begin
                            start_q[i] <= 1'b0;
                            reset_q[i] <= 1'b1;
                        end
                    end
                    // A completing core still has start_q set, so it cannot be
                    // picked here; it becomes eligible on the next edge.
                    if (dispatch_valid) begin
                        start_q[dispatch_idx]      <= 1'b1;
                        reset_q[dispatch_idx]      <= 1'b0;
                        block_id_q[dispatch_idx]   <= blocks_dispatched[7:0];
                        thread_cnt_q[dispatch_idx] <= last_block ? TW'(remaining)
                                                                 : TW'(THREADS_PER_BLOCK);
                        blocks_dispatched          <= blocks_dispatched + 9'd1;
                    end
                    if (blocks_done == total_blocks) done <= 1'b1;
                end
                S_DONE: begin
                    done    <= 1'b1;
                    start_q <= '0;
                    reset_q <= '1;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_block_dispatcher.sv
// Directed self-checking bench for block_dispatcher with 2 cores and
// 4 threads per block; outputs are sampled 2ns after each rising edge.
module tb_block_dispatcher;

    localparam int NC  = 2;
    localparam int TPB = 4;
    localparam int TW  = $clog2(TPB) + 1;

    logic              clk = 1'b0;
    logic              reset;
    logic              start;
    logic              done;
    logic              we;
    logic [7:0]        data;
    logic [7:0]        thread_count;
    logic [NC-1:0]     core_done;
    logic [NC-1:0]     core_start;
    logic [NC-1:0]     core_reset;
    logic [NC*8-1:0]   core_block_id;
    logic [NC*TW-1:0]  core_thread_count;

    int total = 0;
    int bad   = 0;

    block_dispatcher #(
        .NUM_CORES        (NC),
        .THREADS_PER_BLOCK(TPB)
    ) dut (
        .clk                        (clk),
        .reset                      (reset),
        .start                      (start),
        .done                       (done),
        .device_control_write_enable(we),
        .device_control_data        (data),
        .thread_count               (thread_count),
        .core_done                  (core_done),
        .core_start                 (core_start),
        .core_reset                 (core_reset),
        .core_block_id              (core_block_id),
        .core_thread_count          (core_thread_count)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic do_reset();
        reset = 1'b1;
        tick();
        tick();
        reset = 1'b0;
    endtask

    initial begin
        reset = 1'b1; start = 1'b0; we = 1'b0; data = 8'd0; core_done = '0;
        do_reset();

        // Reset values
        check("rst_done",   32'(done), 32'd0);
        check("rst_tc",     32'(thread_count), 32'd0);
        check("rst_start",  32'(core_start), 32'b00);
        check("rst_creset", 32'(core_reset), 32'b11);
        check("rst_bid",    32'(core_block_id), 32'h0000);
        check("rst_ctc",    32'(core_thread_count), 32'o44);

        // DCR = 8: two full blocks, both complete on the same edge
        we = 1'b1; data = 8'd8; tick(); we = 1'b0;
        check("t1_dcr", 32'(thread_count), 32'd8);
        start = 1'b1; tick(); start = 1'b0;
        check("t1_launch_start", 32'(core_start), 32'b00);
        tick();
        check("t1_d0_start",  32'(core_start), 32'b01);
        check("t1_d0_creset", 32'(core_reset), 32'b10);
        check("t1_d0_bid",    32'(core_block_id[7:0]), 32'd0);
        check("t1_d0_ctc",    32'(core_thread_count[2:0]), 32'd4);
        tick();
        check("t1_d1_start", 32'(core_start), 32'b11);
        check("t1_d1_bid",   32'(core_block_id), 32'h0100);
        check("t1_d1_ctc",   32'(core_thread_count), 32'o44);
        check("t1_d1_done",  32'(done), 32'd0);
        core_done = 2'b11; tick(); core_done = 2'b00;
        check("t1_cmp_start",  32'(core_start), 32'b00);
        check("t1_cmp_creset", 32'(core_reset), 32'b11);
        check("t1_cmp_done",   32'(done), 32'd0);
        tick();
        check("t1_done", 32'(done), 32'd1);

        // DONE ignores start
        start = 1'b1; tick(); start = 1'b0; tick();
        check("t6_start",  32'(core_start), 32'b00);
        check("t6_creset", 32'(core_reset), 32'b11);
        check("t6_done",   32'(done), 32'd1);

        // DCR = 10: partial last block, DCR rewritten mid-run
        do_reset();
        check("t2_rst_done", 32'(done), 32'd0);
        we = 1'b1; data = 8'd10; tick(); we = 1'b0;
        start = 1'b1; tick(); start = 1'b0;
        tick();
        tick();
        check("t2_bid01", 32'(core_block_id), 32'h0100);
        check("t2_ctc01", 32'(core_thread_count), 32'o44);
        we = 1'b1; data = 8'd3; core_done = 2'b10; tick(); we = 1'b0; core_done = 2'b00;
        check("t2_c1_start",  32'(core_start), 32'b01);
        check("t2_c1_creset", 32'(core_reset), 32'b10);
        check("t5_dcr3",      32'(thread_count), 32'd3);
        tick();
        check("t2_b2_start", 32'(core_start), 32'b11);
        check("t2_b2_bid",   32'(core_block_id[15:8]), 32'd2);
        check("t2_b2_ctc",   32'(core_thread_count[5:3]), 32'd2);
        check("t2_b2_ctc0",  32'(core_thread_count[2:0]), 32'd4);
        check("t2_b2_done",  32'(done), 32'd0);
        core_done = 2'b01; tick(); core_done = 2'b00;
        check("t2_c0_start", 32'(core_start), 32'b10);
        tick();
        check("t2_wait_start", 32'(core_start), 32'b10);
        check("t2_wait_done",  32'(done), 32'd0);
        core_done = 2'b10; tick(); core_done = 2'b00;
        check("t2_last_done", 32'(done), 32'd0);
        tick();
        check("t2_done", 32'(done), 32'd1);

        // Reset mid-run clears everything including the DCR
        do_reset();
        we = 1'b1; data = 8'd10; tick(); we = 1'b0;
        start = 1'b1; tick(); start = 1'b0;
        tick();
        tick();
        check("t5_run_start", 32'(core_start), 32'b11);
        do_reset();
        check("t5_rst_creset", 32'(core_reset), 32'b11);
        check("t5_rst_start",  32'(core_start), 32'b00);
        check("t5_rst_done",   32'(done), 32'd0);
        check("t5_rst_dcr",    32'(thread_count), 32'd0);
        check("t5_rst_ctc",    32'(core_thread_count), 32'o44);

        // Zero-thread kernel
        we = 1'b1; data = 8'd0; tick(); we = 1'b0;
        start = 1'b1; tick(); start = 1'b0;
        check("t3_e1_done",  32'(done), 32'd0);
        check("t3_e1_start", 32'(core_start), 32'b00);
        tick();
        check("t3_e2_done",  32'(done), 32'd1);
        check("t3_e2_start", 32'(core_start), 32'b00);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
